bus_responder_6502: RTL and testbench
=====================================

Name: bus_responder_6502

Overview:
- Memory-side responder for the `core_6502` external bus (`addr_pin`/`din`/`dout`/`we_pin`/`rd_pin`/`sync`).
- Decodes each bus cycle into three regions: RAM, ROM, and a 16-byte I/O page.
- The I/O page holds a programmable 16-bit interval timer that drives the core's `irq_in`, an opcode-fetch counter, and an 8-bit output port.
- A load port preloads RAM/ROM from a bench or boot loader; it replaces ad-hoc ROM arrays in testbenches and is the synthesizable memory system for the core.

Parameters:
- `RAM_AW`, 11, RAM address width; RAM occupies 0x0000 .. 2^RAM_AW-1.
- `ROM_AW`, 12, ROM address width; ROM occupies 0x10000-2^ROM_AW .. 0xFFFF, so vectors live in ROM.
- `IO_BASE`, 16'hD000, base of the I/O page; decode is `addr_pin[15:4] == IO_BASE[15:4]`.

Ports:
- `clk`  in  1  core clock; same clock as `core_6502`.
- `reset_n`  in  1  asynchronous, active-low reset.
- `addr_pin`  in  16  bus address from core.
- `dout`  in  8  write data from core.
- `dout_oe`  in  1  core data-output enable; writes are qualified by `we_pin & dout_oe`.
- `we_pin`  in  1  write strobe.
- `rd_pin`  in  1  read strobe.
- `sync`  in  1  opcode-fetch cycle marker.
- `din`  out  8  read data to core.
- `irq_out`  out  1  level interrupt request to core `irq_in`.
- `gpio_out`  out  8  output port register.
- `bus_err`  out  1  one-cycle pulse on an unmapped access.
- `load_en`  in  1  preload write enable.
- `load_addr`  in  16  preload address.
- `load_data`  in  8  preload data.

Behaviour:

Reset (`reset_n` low, asynchronous):
- `din`=0x00, `irq_out`=0, `gpio_out`=0x00, `bus_err`=0.
- All I/O registers = 0 and the timer is stopped.
- RAM/ROM contents are not reset.

Bus timing:
- The core presents address and strobes during cycle N; the responder samples them at the posedge ending cycle N.
- Read: `din` is registered at that edge, valid throughout N+1; latency is 1 clock.
- `din` holds its previous value whenever `rd_pin`=0.
- Write (`we_pin & dout_oe`): committed at that edge.
- If `rd_pin` and `we_pin` are both high, the write is performed and `din` holds.

Decode priority: I/O page, then RAM, then ROM.
- Reads of unmapped addresses return 0xFF and pulse `bus_err` for 1 cycle.
- Core writes to ROM are ignored and pulse `bus_err`.
- Core writes to unmapped addresses pulse `bus_err`.

Load port:
- When `load_en`=1, `load_data` is written to RAM or ROM at `load_addr` at the posedge; this is the only way to write ROM.
- A core write in the same cycle is dropped.
- A core read in the same cycle still completes normally, returning pre-write data.
- `load_addr` pointing at I/O or an unmapped address is ignored and does not raise `bus_err`.

I/O registers (offset from `IO_BASE`):
- 0x0 `TLO`: reload low byte latch, read/write.
- 0x1 `THI`: writing it loads reload = {`THI`, `TLO`} and count = reload; reads return the reload high byte.
- 0x2 `CTRL`: bit0 `EN`, bit1 `AUTO`, bit2 `IRQEN`; bits 7:3 read 0.
- 0x3 `STAT`: bit0 `EXP`; writing 1 to bit0 clears it.
- 0x4/0x5 `FLO`/`FHI`: 16-bit fetch counter, read-only.
  - Increments on every posedge where `sync & rd_pin`; wraps 0xFFFF -> 0x0000.
  - Reading `FLO` snapshots `FHI` into a shadow register; `FHI` reads return the shadow.
- 0x6 `OUT`: drives `gpio_out`, read/write.
- 0x7-0xF: reads return 0x00; writes are ignored; no `bus_err`.

Timer (16-bit down-counter):
- Each clock with `EN`=1: if count != 0, count decrements.
- Each clock with `EN`=1: if count == 0, `EXP` is set, then:
  - `AUTO`=1: count = reload.
  - `AUTO`=0: `EN` is cleared by hardware.
- A reload of 0 with `AUTO`=1 sets `EXP` every cycle.
- `irq_out` = `EXP & IRQEN`, registered; it asserts 1 cycle after `EXP` sets.
- If a `STAT` clear coincides with expiry, set wins and `EXP` stays 1.
- A `THI` write coinciding with a decrement wins: count = new reload.
- Writing `CTRL` with `EN`=1 while the timer is already running does not reload the count.

Test Plan:
- Preload ROM 0xF000..0xF004 = A9 01 8D 00 02 and vector 0xFFFC/0xFFFD = 00 F0 via the load port; release reset, run the core -> RAM[0x0200]=0x01; `FLO` read returns 0x02.
- Read 0x0123 after loading 0x5A there -> `din`=0x5A exactly 1 clock after the `rd_pin` cycle. Read 0x8000 -> `din`=0xFF and a single-cycle `bus_err`.
- Core writes 0x33 to 0xF010 -> ROM unchanged and `bus_err` pulse. The same address written via the load port -> reads back 0x33.
- `TLO`=0x03, `THI`=0x00, `CTRL`=0x07 -> `EXP` set 4 clocks after the `EN` write takes effect and `irq_out`=1 one clock later. Subsequent expiries occur every 4 clocks. Write `STAT`=0x01 -> `irq_out` drops unless the clear coincides with an expiry.
- `CTRL`=0x01 (one-shot), reload 2 -> single expiry, then `CTRL` reads 0x00 and the count stays 0.
- Assert `reset_n` low mid-timer-run with `gpio_out`=0xA5 -> all outputs 0 immediately, without waiting for a clock edge. Memory contents are retained across reset.

Source files
------------

// File: rtl/bus_responder_6502.sv
// Memory-side responder for the core_6502 bus: RAM, ROM, and a 16-byte I/O page
// with an interval timer, an opcode-fetch counter and an output port.
module bus_responder_6502 #(
    parameter int          RAM_AW  = 11,
    parameter int          ROM_AW  = 12,
    parameter logic [15:0] IO_BASE = 16'hD000
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [15:0] addr_pin,
    input  logic [7:0]  dout,
    input  logic        dout_oe,
    input  logic        we_pin,
    input  logic        rd_pin,
    input  logic        sync,
    output logic [7:0]  din,
    output logic        irq_out,
    output logic [7:0]  gpio_out,
    output logic        bus_err,
    input  logic        load_en,
    input  logic [15:0] load_addr,
    input  logic [7:0]  load_data
);

    typedef enum logic [1:0] {REG_IO, REG_RAM, REG_ROM, REG_NONE} region_t;

    localparam int RAM_SZ = 1 << RAM_AW;
    localparam int ROM_SZ = 1 << ROM_AW;

    logic [7:0]  ram [RAM_SZ];
    logic [7:0]  rom [ROM_SZ];

    logic [7:0]  tlo;
    logic [15:0] reload;
    logic [15:0] count;
    logic        en, auto_rl, irqen, expd;
    logic [15:0] fcnt;
    logic [7:0]  fhi_shadow;

    region_t     bus_region, load_region;
    logic        core_wr, core_rd, io_wr, expire;
    logic [3:0]  io_off;
    logic [7:0]  rd_data;

    // I/O page wins over RAM, RAM over ROM.
    function automatic region_t decode(input logic [15:0] a);
        if (a[15:4] == IO_BASE[15:4])  return REG_IO;
        if (a[15:RAM_AW] == '0)        return REG_RAM;
        if (a[15:ROM_AW] == '1)        return REG_ROM;
        return REG_NONE;
    endfunction

    assign bus_region  = decode(addr_pin);
    assign load_region = decode(load_addr);
    // A preload owns the cycle: any concurrent core write is dropped.
    assign core_wr = we_pin & dout_oe & ~load_en;
    assign core_rd = rd_pin & ~we_pin;
    assign io_off  = addr_pin[3:0];
    assign io_wr   = core_wr & (bus_region == REG_IO);
    assign expire  = en & (count == 16'd0);

    always_comb begin
        rd_data = 8'hFF;
        case (bus_region)
            REG_IO: begin
                case (io_off)
                    4'h0:    rd_data = tlo;
                    4'h1:    rd_data = reload[15:8];
                    4'h2:    rd_data = {5'b0, irqen, auto_rl, en};
                    4'h3:    rd_data = {7'b0, expd};
                    4'h4:    rd_data = fcnt[7:0];
                    4'h5:    rd_data = fhi_shadow;
                    4'h6:    rd_data = gpio_out;
                    default: rd_data = 8'h00;
                endcase
            end
            REG_RAM: rd_data = ram[addr_pin[RAM_AW-1:0]];
            REG_ROM: rd_data = rom[addr_pin[ROM_AW-1:0]];
            default: rd_data = 8'hFF;
        endcase
    end

    always_ff @(posedge clk) begin
        if (load_en && load_region == REG_RAM)
            ram[load_addr[RAM_AW-1:0]] <= load_data;
        else if (core_wr && bus_region == REG_RAM)
            ram[addr_pin[RAM_AW-1:0]] <= dout;
    end

    always_ff @(posedge clk) begin
        if (load_en && load_region == REG_ROM)
            rom[load_addr[ROM_AW-1:0]] <= load_data;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            din        <= 8'h00;
            bus_err    <= 1'b0;
            irq_out    <= 1'b0;
            gpio_out   <= 8'h00;
            tlo        <= 8'h00;
            reload     <= 16'h0000;
            count      <= 16'h0000;
            en         <= 1'b0;
            auto_rl    <= 1'b0;
            irqen      <= 1'b0;
            expd       <= 1'b0;
            fcnt       <= 16'h0000;
            fhi_shadow <= 8'h00;
        end else begin
            if (core_rd)
                din <= rd_data;
            bus_err <= (core_rd & (bus_region == REG_NONE))
                     | (core_wr & ((bus_region == REG_ROM) | (bus_region == REG_NONE)));
            irq_out <= expd & irqen;
            fcnt    <= fcnt + 16'(sync & rd_pin);
            if (core_rd && bus_region == REG_IO && io_off == 4'h4)
                fhi_shadow <= fcnt[15:8];

            // THI write takes precedence over the timer step.
            if (io_wr && io_off == 4'h1)
                count <= {dout, tlo};
            else if (en)
                count <= expire ? (auto_rl ? reload : count) : count - 16'd1;

            if (io_wr && io_off == 4'h0) tlo <= dout;
            if (io_wr && io_off == 4'h1) reload <= {dout, tlo};
            if (io_wr && io_off == 4'h6) gpio_out <= dout;

            if (io_wr && io_off == 4'h2) begin
                en      <= dout[0];
                auto_rl <= dout[1];
                irqen   <= dout[2];
            end else if (expire && !auto_rl) begin
                en <= 1'b0;
            end

            // Expiry beats a simultaneous software clear.
            if (expire)
                expd <= 1'b1;
            else if (io_wr && io_off == 4'h3 && dout[0])
                expd <= 1'b0;
        end
    end

endmodule

// File: tb/tb_bus_responder_6502.sv
// Directed + randomized bench for bus_responder_6502 with a flat memory/timer model.
module tb_bus_responder_6502;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [15:0] addr_pin = 16'h0000;
    logic [7:0]  dout = 8'h00;
    logic        dout_oe = 1'b0, we_pin = 1'b0, rd_pin = 1'b0, sync = 1'b0;
    logic [7:0]  din;
    logic        irq_out;
    logic [7:0]  gpio_out;
    logic        bus_err;
    logic        load_en = 1'b0;
    logic [15:0] load_addr = 16'h0000;
    logic [7:0]  load_data = 8'h00;

    bus_responder_6502 dut (
        .clk(clk), .reset_n(reset_n), .addr_pin(addr_pin), .dout(dout),
        .dout_oe(dout_oe), .we_pin(we_pin), .rd_pin(rd_pin), .sync(sync),
        .din(din), .irq_out(irq_out), .gpio_out(gpio_out), .bus_err(bus_err),
        .load_en(load_en), .load_addr(load_addr), .load_data(load_data)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    logic [7:0]  ram_m [0:2047];
    logic [7:0]  rom_m [0:4095];
    logic [15:0] addr_list [$];
    logic [7:0]  exp_q [$];

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic is_unmapped(input logic [15:0] a);
        return (a >= 16'h0800) && (a < 16'hF000) && !(a >= 16'hD000 && a <= 16'hD00F);
    endfunction

    function automatic logic [7:0] ref_read(input logic [15:0] a);
        if (a < 16'h0800)  return ram_m[a[10:0]];
        if (a >= 16'hF000) return rom_m[a[11:0]];
        return 8'hFF;
    endfunction

    task automatic do_load(input logic [15:0] a, input logic [7:0] d);
        load_addr = a; load_data = d; load_en = 1'b1;
        tick();
        load_en = 1'b0;
        if (a < 16'h0800) ram_m[a[10:0]] = d;
        else if (a >= 16'hF000) rom_m[a[11:0]] = d;
    endtask

    task automatic bus_read(input logic [15:0] a, input logic s, output logic [7:0] d, output logic e);
        addr_pin = a; rd_pin = 1'b1; sync = s;
        tick();
        d = din; e = bus_err;
        rd_pin = 1'b0; sync = 1'b0;
    endtask

    task automatic bus_write(input logic [15:0] a, input logic [7:0] d, output logic e);
        addr_pin = a; dout = d; we_pin = 1'b1; dout_oe = 1'b1;
        tick();
        e = bus_err;
        we_pin = 1'b0; dout_oe = 1'b0;
        if (a < 16'h0800) ram_m[a[10:0]] = d;
    endtask

    logic [7:0]  d;
    logic        e;
    logic [15:0] a;
    int          r, clr1, clr2;
    logic        exp_m, irq_m;
    logic [7:0]  prog [0:4];

    initial begin
        prog[0] = 8'hA9; prog[1] = 8'h01; prog[2] = 8'h8D; prog[3] = 8'h00; prog[4] = 8'h02;
        reset_n = 1'b1;
        #1 reset_n = 1'b0;
        #2;
        check("rst_din", din, 8'h00);
        check("rst_irq", irq_out, 1'b0);
        check("rst_gpio", gpio_out, 8'h00);
        check("rst_err", bus_err, 1'b0);

        for (int i = 0; i < 5; i++) do_load(16'hF000 + 16'(i), prog[i]);
        do_load(16'hFFFC, 8'h00);
        do_load(16'hFFFD, 8'hF0);
        do_load(16'h0123, 8'h5A);
        #2 reset_n = 1'b1;
        tick();

        // Read latency: data appears only after the sampling edge, then holds.
        addr_pin = 16'h0123; rd_pin = 1'b1;
        check("lat_before", din, 8'h00);
        tick();
        rd_pin = 1'b0;
        check("lat_after", din, 8'h5A);
        tick();
        check("din_hold", din, 8'h5A);

        // Bus pattern of LDA #$01 / STA $0200.
        bus_read(16'hF000, 1'b1, d, e); check("prog0", d, 8'hA9);
        bus_read(16'hF001, 1'b0, d, e); check("prog1", d, 8'h01);
        bus_read(16'hF002, 1'b1, d, e); check("prog2", d, 8'h8D);
        bus_read(16'hF003, 1'b0, d, e); check("prog3", d, 8'h00);
        bus_read(16'hF004, 1'b0, d, e); check("prog4", d, 8'h02);
        bus_write(16'h0200, 8'h01, e);  check("sta_err", e, 1'b0);
        bus_read(16'h0200, 1'b0, d, e); check("ram200", d, 8'h01);
        bus_read(16'hD004, 1'b0, d, e); check("flo", d, 8'h02);
        bus_read(16'hD005, 1'b0, d, e); check("fhi", d, 8'h00);
        bus_read(16'hFFFD, 1'b0, d, e); check("vec_hi", d, 8'hF0);

        bus_read(16'h8000, 1'b0, d, e);
        check("unm_data", d, 8'hFF);
        check("unm_err", e, 1'b1);
        tick();
        check("unm_err_pulse", bus_err, 1'b0);

        do_load(16'hF010, 8'($urandom));
        bus_write(16'hF010, 8'h33, e);  check("romwr_err", e, 1'b1);
        bus_read(16'hF010, 1'b0, d, e); check("rom_kept", d, ref_read(16'hF010));
        do_load(16'hF010, 8'h33);
        bus_read(16'hF010, 1'b0, d, e); check("rom_load", d, 8'h33);

        // Load and core read of the same location in one cycle.
        do_load(16'h0300, 8'h11);
        load_en = 1'b1; load_addr = 16'h0300; load_data = 8'h22;
        addr_pin = 16'h0300; rd_pin = 1'b1;
        tick();
        load_en = 1'b0; rd_pin = 1'b0; ram_m[11'h300] = 8'h22;
        check("ld_rd_old", din, 8'h11);
        bus_read(16'h0300, 1'b0, d, e); check("ld_rd_new", d, 8'h22);

        // Load wins; the simultaneous core write vanishes without an error.
        do_load(16'h0301, 8'h44);
        load_en = 1'b1; load_addr = 16'h0302; load_data = 8'h55;
        addr_pin = 16'h0301; dout = 8'h99; we_pin = 1'b1; dout_oe = 1'b1;
        tick();
        load_en = 1'b0; we_pin = 1'b0; dout_oe = 1'b0; ram_m[11'h302] = 8'h55;
        check("ldwr_err", bus_err, 1'b0);
        bus_read(16'h0301, 1'b0, d, e); check("ldwr_drop", d, 8'h44);
        bus_read(16'h0302, 1'b0, d, e); check("ldwr_load", d, 8'h55);

        do_load(16'hD006, 8'h77);
        check("ld_io_gpio", gpio_out, 8'h00);
        check("ld_io_err", bus_err, 1'b0);

        // Randomized memory traffic against the flat model.
        for (int i = 0; i < 24; i++) begin
            a = ($urandom_range(0, 1) == 0) ? 16'($urandom_range(0, 16'h07FF))
                                            : 16'($urandom_range(16'hF000, 16'hFFFF));
            do_load(a, 8'($urandom));
            addr_list.push_back(a);
        end
        for (int i = 0; i < 8; i++) begin
            a = 16'($urandom_range(0, 16'h07FF));
            bus_write(a, 8'($urandom), e);
            check("rand_wr_err", e, 1'b0);
            addr_list.push_back(a);
        end
        for (int i = 0; i < 30; i++) begin
            if ($urandom_range(0, 3) != 0)
                a = addr_list[$urandom_range(0, addr_list.size() - 1)];
            else
                a = 16'($urandom_range(16'h0800, 16'hCFFF));
            exp_q.push_back(ref_read(a));
            bus_read(a, 1'b0, d, e);
            check("rand_rd", d, exp_q.pop_front());
            check("rand_err", e, is_unmapped(a));
        end

        // I/O register readback and the reserved part of the page.
        bus_write(16'hD000, 8'h34, e);
        bus_write(16'hD001, 8'h12, e);
        bus_read(16'hD000, 1'b0, d, e); check("tlo_rd", d, 8'h34);
        bus_read(16'hD001, 1'b0, d, e); check("thi_rd", d, 8'h12);
        bus_read(16'hD00A, 1'b0, d, e); check("rsv_rd", d, 8'h00); check("rsv_rd_err", e, 1'b0);
        bus_write(16'hD00B, 8'hFF, e);  check("rsv_wr_err", e, 1'b0);

        // Auto-reload timer: expiries every r+1 clocks, irq one clock behind EXP.
        r = $urandom_range(1, 5);
        bus_write(16'hD000, 8'(r), e);
        bus_write(16'hD001, 8'h00, e);
        bus_write(16'hD002, 8'h07, e);
        exp_m = 1'b0;
        clr1 = 2 * (r + 1) + 1;
        clr2 = 4 * (r + 1);
        for (int t = 1; t <= 5 * (r + 1) + 2; t++) begin
            if (t == clr1 || t == clr2) begin
                addr_pin = 16'hD003; dout = 8'h01; we_pin = 1'b1; dout_oe = 1'b1;
            end
            tick();
            we_pin = 1'b0; dout_oe = 1'b0;
            irq_m = exp_m;
            if (t % (r + 1) == 0) exp_m = 1'b1;
            else if (t == clr1 || t == clr2) exp_m = 1'b0;
            check($sformatf("timer_irq_t%0d", t), irq_out, irq_m);
        end
        bus_write(16'hD002, 8'h00, e);
        bus_write(16'hD003, 8'h01, e);

        // One-shot with reload 2: a single expiry on the third clock.
        bus_write(16'hD000, 8'h02, e);
        bus_write(16'hD001, 8'h00, e);
        bus_write(16'hD002, 8'h01, e);
        for (int t = 1; t <= 6; t++) begin
            bus_read(16'hD003, 1'b0, d, e);
            check($sformatf("oneshot_stat_t%0d", t), d, (t >= 4) ? 8'h01 : 8'h00);
        end
        bus_read(16'hD002, 1'b0, d, e); check("oneshot_ctrl", d, 8'h00);
        bus_write(16'hD003, 8'h01, e);
        repeat (8) tick();
        bus_read(16'hD003, 1'b0, d, e); check("oneshot_stays", d, 8'h00);
        check("oneshot_irq", irq_out, 1'b0);

        // Asynchronous reset in the middle of a running timer.
        bus_write(16'hD006, 8'hA5, e);
        check("gpio", gpio_out, 8'hA5);
        bus_read(16'hD006, 1'b0, d, e); check("out_rd", d, 8'hA5);
        bus_write(16'hD000, 8'h01, e);
        bus_write(16'hD001, 8'h00, e);
        bus_write(16'hD002, 8'h07, e);
        bus_read(16'h0123, 1'b0, d, e);
        repeat (3) tick();
        check("pre_rst_irq", irq_out, 1'b1);
        #2 reset_n = 1'b0;
        #1;
        check("arst_din", din, 8'h00);
        check("arst_irq", irq_out, 1'b0);
        check("arst_gpio", gpio_out, 8'h00);
        check("arst_err", bus_err, 1'b0);
        tick();
        #2 reset_n = 1'b1;
        tick();
        bus_read(16'h0123, 1'b0, d, e); check("keep_ram", d, ref_read(16'h0123));
        bus_read(16'hF010, 1'b0, d, e); check("keep_rom", d, 8'h33);
        bus_read(16'hD002, 1'b0, d, e); check("rst_ctrl", d, 8'h00);
        bus_read(16'hD003, 1'b0, d, e); check("rst_stat", d, 8'h00);
        bus_read(16'hD004, 1'b0, d, e); check("rst_flo", d, 8'h00);
        repeat (4) tick();
        check("rst_timer_idle", irq_out, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
